// File: rtl/bcd_mux_7seg_driver_if.sv
// Signal bundle between the BCD counter domain and the multiplexed 7-segment driver.
interface bcd_mux_7seg_driver_if;
  logic [7:0] bcd_in;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic       bcd_err;

  modport master (output bcd_in, input  seg, digit_en, bcd_err);
  modport slave  (input  bcd_in, output seg, digit_en, bcd_err);
endinterface

// File: rtl/bcd_mux_7seg_driver.sv
// Two-digit multiplexed 7-segment driver: synchronises/filters a BCD bus, latches it per
// frame, scans units then tens with all-off guard gaps, blanks leading zero, flags bad BCD.
module bcd_mux_7seg_driver #(
  parameter int unsigned SCAN_PERIOD  = 25000,
  parameter int unsigned GUARD_CYCLES = 500,
  parameter bit          LZ_BLANK     = 1'b1,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic       CLK_50M,
  input  logic       RESET_N,
  input  logic [7:0] bcd_in,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic       bcd_err
);

  if (SCAN_PERIOD < 2 || GUARD_CYCLES < 1 || GUARD_CYCLES >= SCAN_PERIOD) begin : g_bad_params
    $error("bcd_mux_7seg_driver: need SCAN_PERIOD >= 2 and 1 <= GUARD_CYCLES < SCAN_PERIOD");
  end

  localparam int unsigned   TW         = $clog2(SCAN_PERIOD);
  localparam logic [TW-1:0] SCAN_LAST  = TW'(SCAN_PERIOD - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_CYCLES - 1);

  localparam logic [1:0] SHOW_U  = 2'd0;
  localparam logic [1:0] GUARD_A = 2'd1;
  localparam logic [1:0] SHOW_T  = 2'd2;
  localparam logic [1:0] GUARD_B = 2'd3;

  logic [7:0]    sync1_q, sync2_q;
  logic [7:0]    pend_q, pend_d;
  logic [7:0]    disp_q, disp_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  logic       showing, last, err_now, blank;
  logic [3:0] nib;
  logic [6:0] seg_raw;
  logic [1:0] de_raw;

  always_comb begin
    showing = (state_q == SHOW_U) || (state_q == SHOW_T);
    last    = showing ? (timer_q == SCAN_LAST) : (timer_q == GUARD_LAST);
    nib     = (state_q == SHOW_T) ? disp_q[7:4] : disp_q[3:0];
    err_now = showing && (nib > 4'd9);
    blank   = LZ_BLANK && (state_q == SHOW_T) && (disp_q[7:4] == 4'd0);

    // Accept only when the value about to enter sync2 matches what sync2 already holds.
    pend_d  = (sync1_q == sync2_q) ? sync2_q : pend_q;

    state_d = state_q;
    timer_d = timer_q + 1'b1;
    if (last) begin
      timer_d = '0;
      case (state_q)
        SHOW_U:  state_d = GUARD_A;
        GUARD_A: state_d = SHOW_T;
        SHOW_T:  state_d = GUARD_B;
        default: state_d = SHOW_U;
      endcase
    end

    disp_d = ((state_q == GUARD_B) && last) ? pend_q : disp_q;
    err_d  = err_q | err_now;
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pend_q  <= '0;
      disp_q  <= '0;
      state_q <= GUARD_B;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= bcd_in;
      sync2_q <= sync1_q;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // seg_raw bit k is segment a+k, active-high before polarity.
  always_comb begin
    seg_raw = '0;
    de_raw  = '0;
    if (showing) begin
      de_raw = (state_q == SHOW_U) ? 2'b01 : 2'b10;
      if (!blank) begin
        case (nib)
          4'd0:    seg_raw = 7'h3F;
          4'd1:    seg_raw = 7'h06;
          4'd2:    seg_raw = 7'h5B;
          4'd3:    seg_raw = 7'h4F;
          4'd4:    seg_raw = 7'h66;
          4'd5:    seg_raw = 7'h6D;
          4'd6:    seg_raw = 7'h7D;
          4'd7:    seg_raw = 7'h07;
          4'd8:    seg_raw = 7'h7F;
          4'd9:    seg_raw = 7'h6F;
          default: seg_raw = 7'h40;
        endcase
      end
    end
    seg      = ACTIVE_LOW ? ~seg_raw : seg_raw;
    digit_en = ACTIVE_LOW ? ~de_raw  : de_raw;
    bcd_err  = err_q | err_now;
  end

endmodule
